proc_hazard_ctrl: RTL and testbench

//   Pipeline sequencing/hazard controller for the 5-stage TinyRV1 datapath (F/D/X/M/W).

---
 rtl/proc_hazard_ctrl_if.sv | 49 ++++
 rtl/proc_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_proc_hazard_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_hazard_ctrl_if.sv
// Decode-field and control bundle between the TinyRV1 datapath
// and its hazard controller.
interface proc_hazard_ctrl_if;
    logic       d_rs1_en;
    logic [4:0] d_rs1;
    logic       d_rs2_en;
    logic [4:0] d_rs2;
    logic       d_wen;
    logic [4:0] d_rd;
    logic       d_load;
    logic       d_jal;
    logic       d_jr;
    logic       d_br;
    logic       eq_X;

    logic       imemreq_val_F;
    logic       reg_en_F;
    logic       reg_en_D;
    logic [1:0] pc_sel_F;
    logic [1:0] op1_byp_sel_D;
    logic [1:0] op2_byp_sel_D;
    logic       stall_D;
    logic       val_D;
    logic       val_X;
    logic       val_M;
    logic       val_W;
    logic       rf_wen_W;
    logic [4:0] rf_waddr_W;

    modport master (
        output d_rs1_en, d_rs1, d_rs2_en, d_rs2,
        output d_wen, d_rd, d_load, d_jal, d_jr, d_br,
        output eq_X,
        input  imemreq_val_F, reg_en_F, reg_en_D, pc_sel_F,
        input  op1_byp_sel_D, op2_byp_sel_D, stall_D,
        input  val_D, val_X, val_M, val_W,
        input  rf_wen_W, rf_waddr_W
    );

    modport slave (
        input  d_rs1_en, d_rs1, d_rs2_en, d_rs2,
        input  d_wen, d_rd, d_load, d_jal, d_jr, d_br,
        input  eq_X,
        output imemreq_val_F, reg_en_F, reg_en_D, pc_sel_F,
        output op1_byp_sel_D, op2_byp_sel_D, stall_D,
        output val_D, val_X, val_M, val_W,
        output rf_wen_W, rf_waddr_W
    );
endinterface

// File: rtl/proc_hazard_ctrl.sv
// Sequencing / hazard controller for the 5-stage TinyRV1 pipeline:
// bypass selects, load-use stall, jump/branch redirect and squash.
module proc_hazard_ctrl #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    proc_hazard_ctrl_if.slave ctrl
);

    typedef struct packed {
        logic       val;
        logic       wen;
        logic [4:0] rd;
        logic       load;
        logic       br;
    } x_st_t;

    typedef struct packed {
        logic       val;
        logic       wen;
        logic [4:0] rd;
    } mw_st_t;

    x_st_t  x_q, x_d;
    mw_st_t m_q, w_q;
    logic   val_D_q, val_D_d;

    logic   rs1_x, rs1_m, rs1_w;
    logic   rs2_x, rs2_m, rs2_w;
    logic   raw_any, load_use;
    logic   br_taken, stall;

    function automatic logic hit(
        input logic       en,
        input logic [4:0] src,
        input logic       v,
        input logic       w,
        input logic [4:0] rd
    );
        return en && (src != 5'd0) && v && w && (rd == src);
    endfunction

    // Youngest producer wins; W is needed since the RF is not write-through.
    function automatic logic [1:0] pick(
        input logic hx,
        input logic hm,
        input logic hw
    );
        if (hx)      return 2'd1;
        else if (hm) return 2'd2;
        else if (hw) return 2'd3;
        else         return 2'd0;
    endfunction

    always_comb begin
        rs1_x = hit(ctrl.d_rs1_en, ctrl.d_rs1,
                    x_q.val, x_q.wen, x_q.rd);
        rs1_m = hit(ctrl.d_rs1_en, ctrl.d_rs1,
                    m_q.val, m_q.wen, m_q.rd);
        rs1_w = hit(ctrl.d_rs1_en, ctrl.d_rs1,
                    w_q.val, w_q.wen, w_q.rd);
        rs2_x = hit(ctrl.d_rs2_en, ctrl.d_rs2,
                    x_q.val, x_q.wen, x_q.rd);
        rs2_m = hit(ctrl.d_rs2_en, ctrl.d_rs2,
                    m_q.val, m_q.wen, m_q.rd);
        rs2_w = hit(ctrl.d_rs2_en, ctrl.d_rs2,
                    w_q.val, w_q.wen, w_q.rd);

        raw_any  = rs1_x | rs1_m | rs1_w
                 | rs2_x | rs2_m | rs2_w;
        load_use = (rs1_x | rs2_x) & x_q.load;
        br_taken = x_q.val & x_q.br & ~ctrl.eq_X;
        stall    = val_D_q & ~br_taken
                 & (BYPASS_EN ? load_use : raw_any);
    end

    always_comb begin
        ctrl.imemreq_val_F = ~rst;
        ctrl.reg_en_F      = 1'b0;
        ctrl.reg_en_D      = 1'b0;
        ctrl.pc_sel_F      = 2'd0;
        ctrl.op1_byp_sel_D = 2'd0;
        ctrl.op2_byp_sel_D = 2'd0;
        ctrl.stall_D       = 1'b0;
        val_D_d            = val_D_q;
        x_d                = x_q;
        x_d.val            = 1'b0;

        if (!rst) begin
            ctrl.stall_D = stall;
            if (BYPASS_EN) begin
                ctrl.op1_byp_sel_D = pick(rs1_x, rs1_m, rs1_w);
                ctrl.op2_byp_sel_D = pick(rs2_x, rs2_m, rs2_w);
            end

            if (br_taken) begin
                ctrl.pc_sel_F = 2'd3;
                ctrl.reg_en_F = 1'b1;
                ctrl.reg_en_D = 1'b1;
                val_D_d       = 1'b0;
            end else if (!stall) begin
                ctrl.reg_en_F = 1'b1;
                ctrl.reg_en_D = 1'b1;
                x_d.val  = val_D_q;
                x_d.wen  = ctrl.d_wen;
                x_d.rd   = ctrl.d_rd;
                x_d.load = ctrl.d_load;
                x_d.br   = ctrl.d_br;
                // Jumps advance to X but squash the wrong-path fetch.
                if (val_D_q && ctrl.d_jr) begin
                    ctrl.pc_sel_F = 2'd1;
                    val_D_d       = 1'b0;
                end else if (val_D_q && ctrl.d_jal) begin
                    ctrl.pc_sel_F = 2'd2;
                    val_D_d       = 1'b0;
                end else begin
                    val_D_d       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_D_q <= 1'b0;
            x_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            val_D_q <= val_D_d;
            x_q     <= x_d;
            m_q     <= {x_q.val, x_q.wen, x_q.rd};
            w_q     <= m_q;
        end
    end

    assign ctrl.val_D      = val_D_q;
    assign ctrl.val_X      = x_q.val;
    assign ctrl.val_M      = m_q.val;
    assign ctrl.val_W      = w_q.val;
    assign ctrl.rf_wen_W   = w_q.val & w_q.wen;
    assign ctrl.rf_waddr_W = w_q.val ? w_q.rd : 5'd0;

endmodule

// File: tb/tb_proc_hazard_ctrl.sv
// Scoreboard bench for proc_hazard_ctrl: both bypass modes run in
// lockstep against a stage-array reference model plus directed checks.
module tb_proc_hazard_ctrl;

    typedef struct packed {
        logic       rs1_en;
        logic [4:0] rs1;
        logic       rs2_en;
        logic [4:0] rs2;
        logic       wen;
        logic [4:0] rd;
        logic       load;
        logic       jal;
        logic       jr;
        logic       br;
    } dec_t;

    typedef struct packed {
        logic       imem;
        logic       enf;
        logic       en_d;
        logic [1:0] pc;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       stall;
        logic       vd;
        logic       vx;
        logic       vm;
        logic       vw;
        logic       rfw;
        logic [4:0] wa;
    } exp_t;

    logic clk;
    logic rst;
    dec_t drv;
    logic eqv;
    int   n_chk;
    int   n_bad;

    exp_t q0[$];
    exp_t q1[$];
    exp_t o0, o1;

    // model state per instance: index 0=D, 1=X, 2=M, 3=W
    logic       mv[2][4];
    logic       mw[2][4];
    logic [4:0] mr[2][4];
    logic       ml[2][4];
    logic       mb[2][4];
    logic       nv[2][4];
    logic       nw[2][4];
    logic [4:0] nr[2][4];
    logic       nl[2][4];
    logic       nb[2][4];

    proc_hazard_ctrl_if bus0();
    proc_hazard_ctrl_if bus1();

    proc_hazard_ctrl #(.BYPASS_EN(1'b1)) u_byp (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus0.slave)
    );

    proc_hazard_ctrl #(.BYPASS_EN(1'b0)) u_nobyp (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus1.slave)
    );

    assign bus0.d_rs1_en = drv.rs1_en;
    assign bus0.d_rs1    = drv.rs1;
    assign bus0.d_rs2_en = drv.rs2_en;
    assign bus0.d_rs2    = drv.rs2;
    assign bus0.d_wen    = drv.wen;
    assign bus0.d_rd     = drv.rd;
    assign bus0.d_load   = drv.load;
    assign bus0.d_jal    = drv.jal;
    assign bus0.d_jr     = drv.jr;
    assign bus0.d_br     = drv.br;
    assign bus0.eq_X     = eqv;
    assign bus1.d_rs1_en = drv.rs1_en;
    assign bus1.d_rs1    = drv.rs1;
    assign bus1.d_rs2_en = drv.rs2_en;
    assign bus1.d_rs2    = drv.rs2;
    assign bus1.d_wen    = drv.wen;
    assign bus1.d_rd     = drv.rd;
    assign bus1.d_load   = drv.load;
    assign bus1.d_jal    = drv.jal;
    assign bus1.d_jr     = drv.jr;
    assign bus1.d_br     = drv.br;
    assign bus1.eq_X     = eqv;

    assign o0 = {bus0.imemreq_val_F, bus0.reg_en_F, bus0.reg_en_D,
                 bus0.pc_sel_F, bus0.op1_byp_sel_D, bus0.op2_byp_sel_D,
                 bus0.stall_D, bus0.val_D, bus0.val_X, bus0.val_M,
                 bus0.val_W, bus0.rf_wen_W, bus0.rf_waddr_W};
    assign o1 = {bus1.imemreq_val_F, bus1.reg_en_F, bus1.reg_en_D,
                 bus1.pc_sel_F, bus1.op1_byp_sel_D, bus1.op2_byp_sel_D,
                 bus1.stall_D, bus1.val_D, bus1.val_X, bus1.val_M,
                 bus1.val_W, bus1.rf_wen_W, bus1.rf_waddr_W};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic dec_t mk(
        input logic e1, input logic [4:0] r1,
        input logic e2, input logic [4:0] r2,
        input logic w,  input logic [4:0] rd,
        input logic ld, input logic jl,
        input logic j,  input logic b);
        dec_t d;
        d = '{e1, r1, e2, r2, w, rd, ld, jl, j, b};
        return d;
    endfunction

    function automatic dec_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic dec_t alu(input logic [4:0] rd,
                                 input logic [4:0] a,
                                 input logic [4:0] b);
        return mk(1, a, 1, b, 1, rd, 0, 0, 0, 0);
    endfunction
    function automatic dec_t addi(input logic [4:0] rd,
                                  input logic [4:0] a);
        return mk(1, a, 0, 0, 1, rd, 0, 0, 0, 0);
    endfunction
    function automatic dec_t lw(input logic [4:0] rd,
                                input logic [4:0] a);
        return mk(1, a, 0, 0, 1, rd, 1, 0, 0, 0);
    endfunction
    function automatic dec_t jal(input logic [4:0] rd);
        return mk(0, 0, 0, 0, 1, rd, 0, 1, 0, 0);
    endfunction
    function automatic dec_t jr(input logic [4:0] a);
        return mk(1, a, 0, 0, 0, 0, 0, 0, 1, 0);
    endfunction
    function automatic dec_t bne(input logic [4:0] a,
                                 input logic [4:0] b);
        return mk(1, a, 1, b, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic logic hz(input int k, input int s,
                                input logic en,
                                input logic [4:0] src);
        return en && src != 0 && mv[k][s] && mw[k][s]
               && mr[k][s] == src;
    endfunction

    task automatic model(input int k, input bit byp,
                         output exp_t e);
        logic [1:0] s1, s2;
        logic any, ldx, brt, stl;
        s1 = 0; s2 = 0; any = 0; ldx = 0;
        for (int s = 3; s >= 1; s--) begin
            if (hz(k, s, drv.rs1_en, drv.rs1)) begin
                s1 = 2'(s); any = 1;
                if (s == 1 && ml[k][1]) ldx = 1;
            end
            if (hz(k, s, drv.rs2_en, drv.rs2)) begin
                s2 = 2'(s); any = 1;
                if (s == 1 && ml[k][1]) ldx = 1;
            end
        end
        brt = mv[k][1] && mb[k][1] && !eqv;
        stl = mv[k][0] && !brt && (byp ? ldx : any);
        if (!byp) begin s1 = 0; s2 = 0; end

        e = '0;
        e.vd  = mv[k][0];
        e.vx  = mv[k][1];
        e.vm  = mv[k][2];
        e.vw  = mv[k][3];
        e.rfw = mv[k][3] && mw[k][3];
        e.wa  = mv[k][3] ? mr[k][3] : 5'd0;

        for (int s = 0; s < 4; s++) begin
            nv[k][s] = mv[k][s]; nw[k][s] = mw[k][s];
            nr[k][s] = mr[k][s]; nl[k][s] = ml[k][s];
            nb[k][s] = mb[k][s];
        end
        for (int s = 3; s >= 2; s--) begin
            nv[k][s] = mv[k][s-1]; nw[k][s] = mw[k][s-1];
            nr[k][s] = mr[k][s-1];
        end

        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                nv[k][s] = 0; nw[k][s] = 0; nr[k][s] = 0;
                nl[k][s] = 0; nb[k][s] = 0;
            end
        end else begin
            e.imem = 1; e.s1 = s1; e.s2 = s2; e.stall = stl;
            if (brt) begin
                e.pc = 3; e.enf = 1; e.en_d = 1;
                nv[k][0] = 0; nv[k][1] = 0;
            end else if (stl) begin
                nv[k][1] = 0;
            end else begin
                e.enf = 1; e.en_d = 1;
                nv[k][1] = mv[k][0]; nw[k][1] = drv.wen;
                nr[k][1] = drv.rd;   nl[k][1] = drv.load;
                nb[k][1] = drv.br;
                if (mv[k][0] && drv.jr) begin
                    e.pc = 1; nv[k][0] = 0;
                end else if (mv[k][0] && drv.jal) begin
                    e.pc = 2; nv[k][0] = 0;
                end else begin
                    nv[k][0] = 1;
                end
            end
        end
    endtask

    task automatic step(input dec_t d, input logic eq,
                        input logic r);
        exp_t e0, e1;
        @(posedge clk);
        #1;
        drv = d; eqv = eq; rst = r;
        model(0, 1'b1, e0);
        model(1, 1'b0, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(negedge clk);
        chk("sb_byp", 32'(o0), 32'(q0.pop_front()));
        chk("sb_nobyp", 32'(o1), 32'(q1.pop_front()));
        mv = nv; mw = nw; mr = nr; ml = nl; mb = nb;
    endtask

    initial begin
        n_chk = 0; n_bad = 0;
        rst = 1'b1; eqv = 1'b0; drv = '0;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 4; s++) begin
                mv[k][s] = 0; mw[k][s] = 0; mr[k][s] = 0;
                ml[k][s] = 0; mb[k][s] = 0;
            end

        // reset and start-up
        step(nop(), 0, 1);
        step(nop(), 0, 1);
        chk("rst_valD", bus0.val_D, 0);
        chk("rst_valX", bus0.val_X, 0);
        chk("rst_rfwen", bus0.rf_wen_W, 0);
        chk("rst_imem", bus0.imemreq_val_F, 0);
        step(nop(), 0, 0);
        chk("up_imem", bus0.imemreq_val_F, 1);
        chk("up_valD0", bus0.val_D, 0);
        step(addi(1, 0), 0, 0);
        chk("up_valD1", bus0.val_D, 1);

        // bypass from X, M, W
        step(alu(2, 1, 1), 0, 0);
        chk("byX_op1", bus0.op1_byp_sel_D, 1);
        chk("byX_op2", bus0.op2_byp_sel_D, 1);
        chk("byX_stall", bus0.stall_D, 0);
        step(alu(7, 1, 1), 0, 0);
        chk("byM_op1", bus0.op1_byp_sel_D, 2);
        step(alu(8, 1, 0), 0, 0);
        chk("byW_op1", bus0.op1_byp_sel_D, 3);
        chk("byW_op2", bus0.op2_byp_sel_D, 0);

        // load-use
        step(lw(3, 0), 0, 0);
        step(alu(4, 3, 0), 0, 0);
        chk("lu_stall", bus0.stall_D, 1);
        chk("lu_enF", bus0.reg_en_F, 0);
        step(alu(4, 3, 0), 0, 0);
        chk("lu_valX", bus0.val_X, 0);
        chk("lu_op1", bus0.op1_byp_sel_D, 2);
        chk("lu_stall2", bus0.stall_D, 0);

        // taken branch
        step(bne(1, 2), 0, 0);
        step(alu(9, 0, 0), 0, 0);
        chk("br_pc", bus0.pc_sel_F, 3);
        chk("br_enD", bus0.reg_en_D, 1);
        step(nop(), 0, 0);
        chk("br_valD", bus0.val_D, 0);
        chk("br_valX", bus0.val_X, 0);

        // jal, then jr with M bypass, then jr behind a load
        step(jal(10), 0, 0);
        chk("jal_pc", bus0.pc_sel_F, 2);
        step(nop(), 0, 0);
        chk("jal_valD", bus0.val_D, 0);
        chk("jal_valX", bus0.val_X, 1);
        step(lw(5, 0), 0, 0);
        step(nop(), 0, 0);
        step(jr(5), 0, 0);
        chk("jrM_op1", bus0.op1_byp_sel_D, 2);
        chk("jrM_pc", bus0.pc_sel_F, 1);
        step(nop(), 0, 0);
        step(lw(6, 0), 0, 0);
        step(jr(6), 0, 0);
        chk("jrL_stall", bus0.stall_D, 1);
        chk("jrL_pc0", bus0.pc_sel_F, 0);
        step(jr(6), 0, 0);
        chk("jrL_pc1", bus0.pc_sel_F, 1);
        chk("jrL_op1", bus0.op1_byp_sel_D, 2);
        step(nop(), 0, 0);
        step(addi(0, 0), 0, 0);
        step(alu(11, 0, 0), 0, 0);
        chk("x0_op1", bus0.op1_byp_sel_D, 0);

        // no-bypass instance
        step(nop(), 0, 1);
        step(nop(), 0, 1);
        step(nop(), 0, 0);
        step(alu(1, 2, 3), 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(alu(2, 1, 0), 0, 0);
            chk("nb_stall", bus1.stall_D, 1);
            chk("nb_op1", bus1.op1_byp_sel_D, 0);
        end
        step(alu(2, 1, 0), 0, 0);
        chk("nb_go", bus1.stall_D, 0);
        step(alu(1, 0, 0), 0, 0);
        step(bne(4, 5), 0, 0);
        step(alu(6, 1, 0), 0, 0);
        chk("nb_br_stall", bus1.stall_D, 0);
        chk("nb_br_pc", bus1.pc_sel_F, 3);
        step(nop(), 0, 0);
        chk("nb_br_valD", bus1.val_D, 0);
        chk("nb_br_valX", bus1.val_X, 0);
        step(addi(0, 0), 0, 0);
        step(alu(7, 0, 0), 0, 0);
        chk("nb_x0", bus1.stall_D, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            dec_t d;
            d.rs1_en = 1'($urandom_range(0, 1));
            d.rs1    = 5'($urandom_range(0, 3));
            d.rs2_en = 1'($urandom_range(0, 1));
            d.rs2    = 5'($urandom_range(0, 3));
            d.wen    = 1'($urandom_range(0, 1));
            d.rd     = 5'($urandom_range(0, 3));
            d.load   = ($urandom_range(0, 3) == 0);
            d.jal    = ($urandom_range(0, 7) == 0);
            d.jr     = ($urandom_range(0, 7) == 0);
            d.br     = ($urandom_range(0, 4) == 0);
            step(d, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
